dac_out_stage: RTL and testbench
================================

Name: dac_out_stage

Overview:
- Downstream of the PID core: consumes its 14-bit offset-binary control word (midscale 8191) and drives the DAC code.
- Adds three things the loop needs for lock acquisition:
  - a park/sweep/lock mode state machine;
  - a triangle sweep generator for scanning the laser across resonance;
  - a per-cycle slew-rate limiter, plus hard output clamps protecting the actuator.
- The output is registered and bumpless across mode changes.

Parameters:
- DAC_W, 14, DAC code width (offset binary).
- DIV_W, 16, width of the sweep prescaler.
- MIDSCALE, 8191, reset/default output code.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  stage enable; low forces PARK.
- mode_i  in  2  0=PARK, 1=SWEEP, 2=LOCK, 3=PARK.
- pid_i  in  DAC_W  PID output word (LOCK target).
- park_i  in  DAC_W  PARK target code.
- slew_i  in  DAC_W  max |step| per cycle; 0 = unlimited.
- sweep_min_i  in  DAC_W  sweep lower bound.
- sweep_max_i  in  DAC_W  sweep upper bound.
- sweep_step_i  in  DAC_W  sweep increment per sweep tick.
- sweep_div_i  in  DIV_W  sweep tick every sweep_div_i+1 cycles.
- lim_lo_i  in  DAC_W  output clamp low.
- lim_hi_i  in  DAC_W  output clamp high.
- dac_o  out  DAC_W  registered DAC code.
- state_o  out  2  current state (0 PARK, 1 SWEEP, 2 LOCK).
- sweep_dir_o  out  1  1 = sweeping up.
- at_limit_o  out  1  registered; clamp altered this cycle's value.
- slewing_o  out  1  registered; dac_o != target after update.

Behaviour:
- Reset (rst high, synchronous; wins over everything):
  - dac_o=MIDSCALE, state_o=PARK, sweep_dir_o=1, at_limit_o=0, slewing_o=0.
  - Sweep pointer=MIDSCALE, prescaler count=0.
- State register: each cycle, state <= enable_i ? decode(mode_i) : PARK. Any state may go to any other directly. New state governs the next cycle's target (1-cycle mode latency).
- Target per state:
  - PARK: park_i.
  - SWEEP: sweep pointer.
  - LOCK: pid_i.
- Update path, every cycle while not in reset:
  - delta = target - dac_o, computed as 15-bit signed.
  - If slew_i == 0: s = target.
  - Else if delta > slew_i: s = dac_o + slew_i.
  - Else if delta < -slew_i: s = dac_o - slew_i.
  - Else: s = target.
  - Clamp: c = min(max(s, lim_lo_i), lim_hi_i). If lim_lo_i > lim_hi_i, lim_hi_i wins.
  - dac_o <= c; at_limit_o <= (c != s); slewing_o <= (c != target).
- LOCK latency: pid_i change appears on dac_o 1 cycle later when slew-unlimited and inside clamps.
- Sweep generator:
  - Entering SWEEP from another state: pointer <= clamp(dac_o, sweep_min_i, sweep_max_i), dir <= up, prescaler <= 0.
  - Tick when prescaler == sweep_div_i; prescaler then returns to 0, otherwise increments.
  - On tick, up: if pointer + step >= sweep_max_i then pointer <= sweep_max_i, dir <= down; else pointer += step.
  - On tick, down: if pointer - step <= sweep_min_i then pointer <= sweep_min_i, dir <= up; else pointer -= step.
  - All arithmetic is 15-bit, so there is no wrap at 0 or 16383.
  - sweep_step_i == 0: pointer holds.
  - sweep_min_i >= sweep_max_i: pointer pinned to sweep_min_i.
  - Outside SWEEP: pointer and dir hold.
- Bumpless handover: SWEEP->LOCK and LOCK->PARK never jump by more than slew_i per cycle (when slew_i != 0).
- enable_i low mid-sweep or mid-lock: PARK next cycle; dac_o slews to park_i. It is NOT reset to MIDSCALE.
- Config inputs (slew, limits, sweep) are used combinationally every cycle. Changes take effect on the next update.

Decomposition:
- Package pdh_out_pkg:
  - state enum out_state_e {PARK, SWEEP, LOCK};
  - DAC_W; MIDSCALE;
  - shared clamp/min/max functions.
- One sub-module, sweep_gen: prescaler, pointer, direction, and load-on-entry.
- The top level holds the FSM, slew limiter, clamp and output registers.

Test Plan:
- Reset then enable_i=1, mode=LOCK, slew=0, limits 0/16383, pid_i=12000 -> dac_o=8191 during reset; 12000 one cycle after release; at_limit_o=0.
- LOCK, slew=100, dac_o=8191, pid_i=9000 -> dac_o steps 8291, 8391, ... 8991, then 9000; slewing_o=1 until the 9000 cycle, then 0.
- SWEEP, min=1000, max=1300, step=100, div=1, entering with dac_o=8191, slew=0 -> pointer loads 1300, dir up. Then ticks every 2 cycles: turnaround at 1300, 1200, 1100, 1000, turnaround, 1100 ...; sweep_dir_o toggles at the bounds.
- LOCK, lim_lo=2000, lim_hi=6000, pid_i=7000 -> dac_o=6000, at_limit_o=1. pid_i=100 -> 2000. lim_lo=5000, lim_hi=4000 -> dac_o=4000.
- SWEEP at 1200, then enable_i=0 with park_i=8191, slew=500 -> state_o=PARK next cycle; dac_o rises by 500 per cycle to 8191. Re-enable SWEEP -> pointer reloads clamp(8191)=1300.
- rst asserted mid-slew in LOCK -> next edge dac_o=8191, state_o=PARK, sweep_dir_o=1, status flags 0.

Source files
------------

// File: rtl/dac_out_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdh_out_pkg
//  Description : Shared types, constants and saturating helpers for the DAC
//                output stage (state encoding, 15-bit signed working type,
//                clamp/min/max, mode decode).
//  Revision    : 1.0  initial release
// ============================================================================
package pdh_out_pkg;

    localparam int DAC_W    = 14;
    localparam int DIV_W    = 16;
    localparam int MIDSCALE = 8191;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        SWEEP = 2'd1,
        LOCK  = 2'd2
    } out_state_e;

    // One extra bit so differences and sums of codes never wrap.
    typedef logic signed [DAC_W:0] ext_t;

    function automatic ext_t to_ext(input logic [DAC_W-1:0] v);
        return ext_t'({1'b0, v});
    endfunction

    function automatic ext_t max_ext(input ext_t a, input ext_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic ext_t min_ext(input ext_t a, input ext_t b);
        return (a < b) ? a : b;
    endfunction

    // Upper bound applied last, so an inverted window resolves to hi.
    function automatic ext_t clamp_ext(input ext_t v, input ext_t lo, input ext_t hi);
        return min_ext(max_ext(v, lo), hi);
    endfunction

    // Back to a DAC code; negative values cannot occur but saturate to 0.
    function automatic logic [DAC_W-1:0] sat_code(input ext_t v);
        return v[DAC_W] ? '0 : v[DAC_W-1:0];
    endfunction

    function automatic out_state_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SWEEP;
            2'd2:    return LOCK;
            default: return PARK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_out_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_out_stage_if
//  Description : Control/config/status bundle of the DAC output stage.
//                master = controller side, slave = output stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface dac_out_stage_if #(
    parameter int DAC_W = pdh_out_pkg::DAC_W,
    parameter int DIV_W = pdh_out_pkg::DIV_W
);
    logic             enable_i;
    logic [1:0]       mode_i;
    logic [DAC_W-1:0] pid_i;
    logic [DAC_W-1:0] park_i;
    logic [DAC_W-1:0] slew_i;
    logic [DAC_W-1:0] sweep_min_i;
    logic [DAC_W-1:0] sweep_max_i;
    logic [DAC_W-1:0] sweep_step_i;
    logic [DIV_W-1:0] sweep_div_i;
    logic [DAC_W-1:0] lim_lo_i;
    logic [DAC_W-1:0] lim_hi_i;
    logic [DAC_W-1:0] dac_o;
    logic [1:0]       state_o;
    logic             sweep_dir_o;
    logic             at_limit_o;
    logic             slewing_o;

    modport master (
        output enable_i, mode_i, pid_i, park_i, slew_i,
               sweep_min_i, sweep_max_i, sweep_step_i, sweep_div_i,
               lim_lo_i, lim_hi_i,
        input  dac_o, state_o, sweep_dir_o, at_limit_o, slewing_o
    );

    modport slave (
        input  enable_i, mode_i, pid_i, park_i, slew_i,
               sweep_min_i, sweep_max_i, sweep_step_i, sweep_div_i,
               lim_lo_i, lim_hi_i,
        output dac_o, state_o, sweep_dir_o, at_limit_o, slewing_o
    );
endinterface
`default_nettype wire

// File: rtl/dac_out_stage_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_gen
//  Description : Triangle sweep generator: prescaler, pointer and direction.
//                Loads from the current DAC code on entry to SWEEP, then
//                bounces between sweep_min and sweep_max one step per tick.
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_gen #(
    parameter int DAC_W    = 14,
    parameter int DIV_W    = 16,
    parameter int MIDSCALE = 8191
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_sweep,
    input  logic             i_enter,
    input  logic [DAC_W-1:0] i_dac,
    input  logic [DAC_W-1:0] i_min,
    input  logic [DAC_W-1:0] i_max,
    input  logic [DAC_W-1:0] i_step,
    input  logic [DIV_W-1:0] i_div,
    output logic [DAC_W-1:0] o_ptr,
    output logic             o_dir
);
    import pdh_out_pkg::*;

    logic [DAC_W-1:0] r_ptr;
    logic             r_dir;
    logic [DIV_W-1:0] r_cnt;

    logic [DAC_W-1:0] w_ptr_nxt;
    logic             w_dir_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DAC_W:0]   w_up_u;
    ext_t             w_dn_e;
    ext_t             w_min_e;
    ext_t             w_load_e;
    logic             w_tick;
    logic             w_pinned;

    assign w_min_e  = to_ext(i_min);
    assign w_up_u   = {1'b0, r_ptr} + {1'b0, i_step};
    assign w_dn_e   = to_ext(r_ptr) - to_ext(i_step);
    assign w_load_e = clamp_ext(to_ext(i_dac), w_min_e, to_ext(i_max));
    assign w_pinned = (i_min >= i_max);
    assign w_tick   = (r_cnt == i_div);

    // Next pointer/direction/prescaler: load on entry, step on tick, else hold.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_dir_nxt = r_dir;
        w_cnt_nxt = r_cnt;
        if (i_enter) begin
            w_ptr_nxt = w_pinned ? i_min : sat_code(w_load_e);
            w_dir_nxt = 1'b1;
            w_cnt_nxt = '0;
        end else if (i_in_sweep) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
            if (w_pinned) begin
                w_ptr_nxt = i_min;
            end else if (w_tick && (i_step != '0)) begin
                if (r_dir) begin
                    if (w_up_u >= {1'b0, i_max}) begin
                        w_ptr_nxt = i_max;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_ptr_nxt = w_up_u[DAC_W-1:0];
                    end
                end else begin
                    if (w_dn_e <= w_min_e) begin
                        w_ptr_nxt = i_min;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = sat_code(w_dn_e);
                    end
                end
            end
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= DAC_W'(MIDSCALE);
            r_dir <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_dir <= w_dir_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_ptr = r_ptr;
    assign o_dir = r_dir;

endmodule
`default_nettype wire

// File: rtl/dac_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dac_out_stage
//  Description : DAC output stage after the PID core. Park/sweep/lock mode
//                FSM, per-cycle slew limiter, hard output clamp and
//                registered DAC code with status flags.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_out_stage #(
    parameter int DAC_W    = pdh_out_pkg::DAC_W,
    parameter int DIV_W    = pdh_out_pkg::DIV_W,
    parameter int MIDSCALE = pdh_out_pkg::MIDSCALE
) (
    input  logic             clk,
    input  logic             rst,
    dac_out_stage_if.slave   bus
);
    import pdh_out_pkg::*;

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [DAC_W-1:0] r_dac;
    logic             r_at_limit;
    logic             r_slewing;

    logic [DAC_W-1:0] w_target;
    logic [DAC_W-1:0] w_ptr;
    logic             w_dir;
    ext_t             w_dac_e;
    ext_t             w_tgt_e;
    ext_t             w_slew_e;
    ext_t             w_delta_e;
    ext_t             w_s_e;
    ext_t             w_c_e;

    // Mode decode; a disabled stage always parks.
    always_comb begin
        w_state_nxt = PARK;
        if (bus.enable_i) begin
            w_state_nxt = decode_mode(bus.mode_i);
        end
    end

    // Mode register; the new mode selects the target from the next cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PARK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target selected by the registered mode.
    always_comb begin
        w_target = bus.park_i;
        case (r_state)
            SWEEP:   w_target = w_ptr;
            LOCK:    w_target = bus.pid_i;
            default: w_target = bus.park_i;
        endcase
    end

    assign w_dac_e   = to_ext(r_dac);
    assign w_tgt_e   = to_ext(w_target);
    assign w_slew_e  = to_ext(bus.slew_i);
    assign w_delta_e = w_tgt_e - w_dac_e;

    // Slew limiter: move at most slew_i toward the target (0 = no limit).
    always_comb begin
        w_s_e = w_tgt_e;
        if (bus.slew_i != '0) begin
            if (w_delta_e > w_slew_e) begin
                w_s_e = w_dac_e + w_slew_e;
            end else if (w_delta_e < -w_slew_e) begin
                w_s_e = w_dac_e - w_slew_e;
            end
        end
    end

    assign w_c_e = clamp_ext(w_s_e, to_ext(bus.lim_lo_i), to_ext(bus.lim_hi_i));

    // Output code and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dac      <= DAC_W'(MIDSCALE);
            r_at_limit <= 1'b0;
            r_slewing  <= 1'b0;
        end else begin
            r_dac      <= sat_code(w_c_e);
            r_at_limit <= (w_c_e != w_s_e);
            r_slewing  <= (w_c_e != w_tgt_e);
        end
    end

    // Pointer is loaded on the same edge the FSM enters SWEEP, so the first
    // SWEEP cycle already targets the clamped current output (bumpless).
    sweep_gen #(
        .DAC_W    (DAC_W),
        .DIV_W    (DIV_W),
        .MIDSCALE (MIDSCALE)
    ) u_sweep_gen (
        .clk        (clk),
        .rst        (rst),
        .i_in_sweep (r_state == SWEEP),
        .i_enter    ((w_state_nxt == SWEEP) && (r_state != SWEEP)),
        .i_dac      (r_dac),
        .i_min      (bus.sweep_min_i),
        .i_max      (bus.sweep_max_i),
        .i_step     (bus.sweep_step_i),
        .i_div      (bus.sweep_div_i),
        .o_ptr      (w_ptr),
        .o_dir      (w_dir)
    );

    assign bus.dac_o       = r_dac;
    assign bus.state_o     = r_state;
    assign bus.sweep_dir_o = w_dir;
    assign bus.at_limit_o  = r_at_limit;
    assign bus.slewing_o   = r_slewing;

endmodule
`default_nettype wire

// File: tb/tb_dac_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_out_stage
//  Description : Scoreboard bench for dac_out_stage. Directed mode sequences
//                followed by randomized traffic, checked against a
//                behavioural model of the output stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_out_stage;
    localparam int DAC_W = 14;
    localparam int DIV_W = 16;
    localparam int MID   = 8191;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_out_stage_if #(.DAC_W(DAC_W), .DIV_W(DIV_W)) bus ();

    dac_out_stage #(
        .DAC_W    (DAC_W),
        .DIV_W    (DIV_W),
        .MIDSCALE (MID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int dac;
        int st;
        int dir;
        int at;
        int sl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: output code, mode, sweep pointer/direction/prescaler.
    int m_dac, m_state, m_ptr, m_dir, m_cnt;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Predict outputs after the coming clock edge from current inputs.
    task automatic model_step(output exp_t e);
        int tgt, d, s, c, lo, hi, sl, nst, mn, mx, stp, dv;
        bit tick;
        if (rst) begin
            m_dac = MID; m_state = 0; m_ptr = MID; m_dir = 1; m_cnt = 0;
            e = '{MID, 0, 1, 0, 0};
            return;
        end
        lo  = int'(bus.lim_lo_i);  hi = int'(bus.lim_hi_i);
        sl  = int'(bus.slew_i);
        mn  = int'(bus.sweep_min_i); mx = int'(bus.sweep_max_i);
        stp = int'(bus.sweep_step_i); dv = int'(bus.sweep_div_i);
        if (m_state == 1)      tgt = m_ptr;
        else if (m_state == 2) tgt = int'(bus.pid_i);
        else                   tgt = int'(bus.park_i);
        d = tgt - m_dac;
        if (sl == 0 || (d <= sl && d >= -sl)) s = tgt;
        else if (d > 0)                         s = m_dac + sl;
        else                                    s = m_dac - sl;
        c = s;
        if (c < lo) c = lo;
        if (c > hi) c = hi;
        if (!bus.enable_i)         nst = 0;
        else if (bus.mode_i == 1)  nst = 1;
        else if (bus.mode_i == 2)  nst = 2;
        else                       nst = 0;
        if (nst == 1 && m_state != 1) begin
            if (mn >= mx)        m_ptr = mn;
            else if (m_dac < mn) m_ptr = mn;
            else if (m_dac > mx) m_ptr = mx;
            else                 m_ptr = m_dac;
            m_dir = 1;
            m_cnt = 0;
        end else if (m_state == 1) begin
            tick  = (m_cnt == dv);
            m_cnt = tick ? 0 : (m_cnt + 1) % 65536;
            if (mn >= mx) begin
                m_ptr = mn;
            end else if (tick && stp != 0) begin
                if (m_dir == 1) begin
                    if (m_ptr + stp >= mx) begin m_ptr = mx; m_dir = 0; end
                    else m_ptr = m_ptr + stp;
                end else begin
                    if (m_ptr - stp <= mn) begin m_ptr = mn; m_dir = 1; end
                    else m_ptr = m_ptr - stp;
                end
            end
        end
        m_dac   = c;
        m_state = nst;
        e = '{c, nst, m_dir, int'(c != s), int'(c != tgt)};
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step_cycle();
        exp_t e;
        model_step(e);
        q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [DAC_W-1:0] rnd_code();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return '0;
        if (k == 1) return 14'd16383;
        if (k == 2) return 14'(MID);
        return 14'($urandom_range(0, 16383));
    endfunction

    // Monitor: every output cycle is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("dac_o",       int'(bus.dac_o),       e.dac);
                check("state_o",     int'(bus.state_o),     e.st);
                check("sweep_dir_o", int'(bus.sweep_dir_o), e.dir);
                check("at_limit_o",  int'(bus.at_limit_o),  e.at);
                check("slewing_o",   int'(bus.slewing_o),   e.sl);
            end
        end
    end

    initial begin
        bus.enable_i     = 1'b1;
        bus.mode_i       = 2'd2;
        bus.pid_i        = 14'd12000;
        bus.park_i       = 14'd8191;
        bus.slew_i       = '0;
        bus.sweep_min_i  = 14'd1000;
        bus.sweep_max_i  = 14'd1300;
        bus.sweep_step_i = 14'd100;
        bus.sweep_div_i  = 16'd1;
        bus.lim_lo_i     = '0;
        bus.lim_hi_i     = 14'd16383;
        rst              = 1'b1;
        @(negedge clk);

        // Reset then LOCK, unlimited slew.
        repeat (3) step_cycle();
        rst = 1'b0;
        repeat (4) step_cycle();

        // Slew-limited approach from midscale to 9000.
        bus.pid_i = 14'd8191;
        repeat (2) step_cycle();
        bus.slew_i = 14'd100;
        bus.pid_i  = 14'd9000;
        repeat (12) step_cycle();

        // Sweep 1000..1300 entered from midscale.
        bus.slew_i = '0;
        bus.pid_i  = 14'd8191;
        repeat (2) step_cycle();
        bus.mode_i = 2'd1;
        repeat (20) step_cycle();

        // Disable mid-sweep: park at midscale with slew 500, then re-enter.
        bus.slew_i   = 14'd500;
        bus.enable_i = 1'b0;
        repeat (16) step_cycle();
        bus.enable_i = 1'b1;
        repeat (6) step_cycle();

        // Clamp window, including an inverted window.
        bus.slew_i   = '0;
        bus.mode_i   = 2'd2;
        bus.lim_lo_i = 14'd2000;
        bus.lim_hi_i = 14'd6000;
        bus.pid_i    = 14'd7000;
        repeat (3) step_cycle();
        bus.pid_i = 14'd100;
        repeat (3) step_cycle();
        bus.lim_lo_i = 14'd5000;
        bus.lim_hi_i = 14'd4000;
        repeat (3) step_cycle();
        bus.lim_lo_i = '0;
        bus.lim_hi_i = 14'd16383;

        // Reset in the middle of a slew.
        bus.slew_i = 14'd50;
        bus.pid_i  = 14'd16000;
        repeat (5) step_cycle();
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        repeat (3) step_cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) bus.mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.enable_i = ~bus.enable_i;
            if ($urandom_range(0, 3) == 0)  bus.pid_i = rnd_code();
            if ($urandom_range(0, 31) == 0) bus.park_i = rnd_code();
            if ($urandom_range(0, 31) == 0)
                bus.slew_i = ($urandom_range(0, 3) == 0) ? '0 : 14'($urandom_range(1, 2000));
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.lim_lo_i = '0;
                    bus.lim_hi_i = 14'd16383;
                end else begin
                    bus.lim_lo_i = rnd_code();
                    bus.lim_hi_i = rnd_code();
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                bus.sweep_min_i  = rnd_code();
                bus.sweep_max_i  = rnd_code();
                bus.sweep_step_i = ($urandom_range(0, 7) == 0) ? '0 : 14'($urandom_range(1, 9000));
                bus.sweep_div_i  = 16'($urandom_range(0, 3));
            end
            step_cycle();
        end
        rst = 1'b0;

        // Let the last prediction be compared.
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
